// File: rtl/tilemap_mixer_if.sv
// Pixel request/result and CPU register bus for tilemap_mixer.
interface tilemap_mixer_if;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [15:0] reg_data;
  logic        pixel_re;
  logic [12:0] pixel_addr;
  logic        pixel_valid;
  logic [7:0]  pixel_data;

  modport master (
    output reg_we, reg_addr, reg_data, pixel_re, pixel_addr,
    input  pixel_valid, pixel_data
  );

  modport slave (
    input  reg_we, reg_addr, reg_data, pixel_re, pixel_addr,
    output pixel_valid, pixel_data
  );
endinterface

// File: rtl/tilemap_mixer.sv
// Multi-layer tilemap renderer: 5-cycle pixel pipeline, per-layer scroll/enable, priority mix over bg.
// Build option TILEMAP_MIXER_SHADOW_EN: register writes are staged and committed at pixel 0.
module tilemap_mixer #(
  parameter int LAYERS   = 2,
  parameter int SCREEN_W = 96,
  parameter int SCREEN_H = 64,
  parameter int MAP_COLS = 16,
  parameter int MAP_ROWS = 16,
  parameter int TILE_AW  = $clog2(MAP_COLS * MAP_ROWS)
) (
  input  logic                      clk,
  input  logic                      rst,
  tilemap_mixer_if.slave            bus,
  output logic [LAYERS*TILE_AW-1:0] tile_addr,
  input  logic [LAYERS*16-1:0]      tile_q,
  output logic [LAYERS*11-1:0]      font_addr,
  input  logic [LAYERS*8-1:0]       font_q
);
  localparam int          CX_W   = $clog2(MAP_COLS);
  localparam int          CY_W   = $clog2(MAP_ROWS);
  localparam int          MX_W   = CX_W + 3;
  localparam int          MY_W   = CY_W + 3;
  localparam logic [13:0] PIXELS = 14'(SCREEN_W * SCREEN_H);

  logic [LAYERS-1:0][MX_W-1:0] cfg_sx_reg;
  logic [LAYERS-1:0][MY_W-1:0] cfg_sy_reg;
  logic [LAYERS-1:0]           cfg_en_reg;
  logic [7:0]                  cfg_bg_reg;

  logic [LAYERS-1:0][MX_W-1:0] use_sx;
  logic [LAYERS-1:0][MY_W-1:0] use_sy;
  logic [LAYERS-1:0]           use_en;
  logic [7:0]                  use_bg;

  logic                        unused_reg_bits;
  assign unused_reg_bits = ^bus.reg_data;

  // CPU writes land here: the active set in immediate mode, the shadow set otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_sx_reg <= '0;
      cfg_sy_reg <= '0;
      cfg_en_reg <= LAYERS'(1);
      cfg_bg_reg <= '0;
    end else if (bus.reg_we) begin
      for (int i = 0; i < LAYERS; i++) begin
        if (bus.reg_addr == 4'(4 * i))     cfg_sx_reg[i] <= bus.reg_data[MX_W-1:0];
        if (bus.reg_addr == 4'(4 * i + 1)) cfg_sy_reg[i] <= bus.reg_data[MY_W-1:0];
        if (bus.reg_addr == 4'(4 * i + 2)) cfg_en_reg[i] <= bus.reg_data[0];
      end
      if (bus.reg_addr == 4'd15) cfg_bg_reg <= bus.reg_data[7:0];
    end
  end

`ifdef TILEMAP_MIXER_SHADOW_EN
  logic [LAYERS-1:0][MX_W-1:0] act_sx_reg;
  logic [LAYERS-1:0][MY_W-1:0] act_sy_reg;
  logic [LAYERS-1:0]           act_en_reg;
  logic [7:0]                  act_bg_reg;
  logic                        commit;

  assign commit = bus.pixel_re && (bus.pixel_addr == 13'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      act_sx_reg <= '0;
      act_sy_reg <= '0;
      act_en_reg <= LAYERS'(1);
      act_bg_reg <= '0;
    end else if (commit) begin
      act_sx_reg <= cfg_sx_reg;
      act_sy_reg <= cfg_sy_reg;
      act_en_reg <= cfg_en_reg;
      act_bg_reg <= cfg_bg_reg;
    end
  end

  // The frame-start request already sees the values it commits
  assign use_sx = commit ? cfg_sx_reg : act_sx_reg;
  assign use_sy = commit ? cfg_sy_reg : act_sy_reg;
  assign use_en = commit ? cfg_en_reg : act_en_reg;
  assign use_bg = commit ? cfg_bg_reg : act_bg_reg;
`else
  assign use_sx = cfg_sx_reg;
  assign use_sy = cfg_sy_reg;
  assign use_en = cfg_en_reg;
  assign use_bg = cfg_bg_reg;
`endif

  logic [12:0] px;
  logic [12:0] py;
  logic        oob;

  assign px  = bus.pixel_addr % 13'(SCREEN_W);
  assign py  = bus.pixel_addr / 13'(SCREEN_W);
  assign oob = {1'b0, bus.pixel_addr} >= PIXELS;

  logic                        v1_reg, v2_reg, v3_reg, v4_reg;
  logic [LAYERS-1:0][2:0]      bit1_reg, bit2_reg, bit3_reg, bit4_reg;
  logic [LAYERS-1:0][2:0]      row1_reg, row2_reg;
  logic [LAYERS-1:0][7:0]      col3_reg, col4_reg;
  logic [LAYERS-1:0]           en1_reg, en2_reg, en3_reg, en4_reg;
  logic [7:0]                  bg1_reg, bg2_reg, bg3_reg, bg4_reg;

  logic [LAYERS-1:0][MX_W-1:0] mx;
  logic [LAYERS-1:0][MY_W-1:0] my;
  logic [LAYERS-1:0]           opaque;
  logic [7:0]                  mix_px;

  genvar gi;
  generate
    for (gi = 0; gi < LAYERS; gi++) begin : g_layer
      logic [7:0] glyph_row;
      // Map wrap-around falls out of truncating to the map width
      assign mx[gi]     = MX_W'(px + 13'(use_sx[gi]));
      assign my[gi]     = MY_W'(py + 13'(use_sy[gi]));
      assign glyph_row  = font_q[gi*8 +: 8];
      assign opaque[gi] = en4_reg[gi] & glyph_row[3'd7 - bit4_reg[gi]];
    end
  endgenerate

  always_comb begin
    mix_px = bg4_reg;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) mix_px = col4_reg[i];
    end
  end

  // Slot metadata needs no reset: nothing reads it without a matching valid bit
  always_ff @(posedge clk) begin
    for (int i = 0; i < LAYERS; i++) begin
      bit1_reg[i] <= mx[i][2:0];
      row1_reg[i] <= my[i][2:0];
      col3_reg[i] <= tile_q[i*16+8 +: 8];
    end
    en1_reg  <= use_en & {LAYERS{~oob}};
    bg1_reg  <= use_bg;
    bit2_reg <= bit1_reg;
    row2_reg <= row1_reg;
    en2_reg  <= en1_reg;
    bg2_reg  <= bg1_reg;
    bit3_reg <= bit2_reg;
    en3_reg  <= en2_reg;
    bg3_reg  <= bg2_reg;
    bit4_reg <= bit3_reg;
    col4_reg <= col3_reg;
    en4_reg  <= en3_reg;
    bg4_reg  <= bg3_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg          <= 1'b0;
      v2_reg          <= 1'b0;
      v3_reg          <= 1'b0;
      v4_reg          <= 1'b0;
      tile_addr       <= '0;
      font_addr       <= '0;
      bus.pixel_valid <= 1'b0;
      bus.pixel_data  <= 8'd0;
    end else begin
      v1_reg          <= bus.pixel_re;
      v2_reg          <= v1_reg;
      v3_reg          <= v2_reg;
      v4_reg          <= v3_reg;
      bus.pixel_valid <= v4_reg;
      if (v4_reg) bus.pixel_data <= mix_px;
      for (int i = 0; i < LAYERS; i++) begin
        if (bus.pixel_re)
          tile_addr[i*TILE_AW +: TILE_AW] <= {my[i][MY_W-1:3], mx[i][MX_W-1:3]};
        if (v2_reg)
          font_addr[i*11 +: 11] <= {tile_q[i*16 +: 8], row2_reg[i]};
      end
    end
  end
endmodule

// File: tb/tb_tilemap_mixer.sv
// Directed bench for tilemap_mixer with behavioural tile RAM / glyph ROM and a pixel reference model.
module tb_tilemap_mixer;
  localparam int LAYERS  = 2;
  localparam int TILE_AW = 8;

  logic clk;
  logic rst;
  logic [LAYERS*TILE_AW-1:0] tile_addr;
  logic [LAYERS*16-1:0]      tile_q;
  logic [LAYERS*11-1:0]      font_addr;
  logic [LAYERS*8-1:0]       font_q;

  tilemap_mixer_if bus ();

  tilemap_mixer #(.LAYERS(LAYERS)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tile_addr (tile_addr),
    .tile_q    (tile_q),
    .font_addr (font_addr),
    .font_q    (font_q)
  );

  logic [15:0] tile_mem [LAYERS][256];
  logic [7:0]  font_mem [LAYERS][2048];

  always @(posedge clk) begin
    for (int l = 0; l < LAYERS; l++) begin
      tile_q[l*16 +: 16] <= tile_mem[l][tile_addr[l*TILE_AW +: TILE_AW]];
      font_q[l*8 +: 8]   <= font_mem[l][font_addr[l*11 +: 11]];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_sx [LAYERS];
  int m_sy [LAYERS];
  int m_en [LAYERS];
  logic [7:0] m_bg;
  logic [7:0] exp_q [96];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [7:0] e);
    check(tag, {23'd0, bus.pixel_valid, bus.pixel_data}, {23'd0, 1'b1, e});
  endtask

  task automatic check_nv(input string tag);
    check(tag, {31'd0, bus.pixel_valid}, 32'd0);
  endtask

  function automatic logic [7:0] model(input int a);
    int px, py, mx, my;
    logic [15:0] t;
    logic [7:0]  g;
    if (a >= 96 * 64) return m_bg;
    px = a % 96;
    py = a / 96;
    for (int l = 0; l < LAYERS; l++) begin
      mx = (px + m_sx[l]) % 128;
      my = (py + m_sy[l]) % 128;
      t  = tile_mem[l][(my / 8) * 16 + mx / 8];
      g  = font_mem[l][t[7:0] * 8 + my % 8];
      if (m_en[l] != 0 && g[7 - mx % 8]) return t[15:8];
    end
    return m_bg;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LAYERS; l++) begin
      m_sx[l] = 0;
      m_sy[l] = 0;
      m_en[l] = (l == 0) ? 1 : 0;
    end
    m_bg = 8'h00;
  endtask

  task automatic wr_reg(input int a, input int d);
    bus.reg_we   = 1'b1;
    bus.reg_addr = 4'(a);
    bus.reg_data = 16'(d);
    tick();
    bus.reg_we = 1'b0;
    if (a == 15) m_bg = 8'(d);
    else if (a / 4 < LAYERS) begin
      case (a % 4)
        0: m_sx[a/4] = d % 128;
        1: m_sy[a/4] = d % 128;
        2: m_en[a/4] = d % 2;
        default: ;
      endcase
    end
`ifdef TILEMAP_MIXER_SHADOW_EN
    bus.pixel_re   = 1'b1;
    bus.pixel_addr = 13'd0;
    tick();
    bus.pixel_re = 1'b0;
    repeat (6) tick();
`endif
  endtask

  // One isolated request: no valid at N+4, result at N+5
  task automatic pix(input string tag, input int a, input logic [7:0] e);
    bus.pixel_re   = 1'b1;
    bus.pixel_addr = 13'(a);
    tick();
    bus.pixel_re = 1'b0;
    repeat (3) tick();
    check_nv({tag, "_early"});
    tick();
    check_px(tag, e);
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.reg_we     = 1'b0;
    bus.reg_addr   = 4'd0;
    bus.reg_data   = 16'd0;
    bus.pixel_re   = 1'b0;
    bus.pixel_addr = 13'd0;
    for (int l = 0; l < LAYERS; l++) begin
      for (int i = 0; i < 256; i++)  tile_mem[l][i] = 16'($urandom);
      for (int i = 0; i < 2048; i++) font_mem[l][i] = 8'($urandom);
    end
    tile_mem[0][0]     = 16'hE041;
    tile_mem[0][1]     = 16'h1C50;
    tile_mem[0][15]    = 16'h1F42;
    font_mem[0][11'h208] = 8'h84;
    font_mem[0][11'h210] = 8'h01;
    font_mem[0][11'h280] = 8'h84;
    tile_mem[1][1]     = 16'h0350;
    font_mem[1][11'h280] = 8'hC0;
    model_reset();

    repeat (3) tick();
    check("rst_valid", {31'd0, bus.pixel_valid}, 32'd0);
    check("rst_data", {24'd0, bus.pixel_data}, 32'd0);
    check("rst_tile_addr", 32'(tile_addr), 32'd0);
    check("rst_font_addr", 32'(font_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Single request: latency of each stage
    bus.pixel_re   = 1'b1;
    bus.pixel_addr = 13'd0;
    tick();
    bus.pixel_re = 1'b0;
    check("single_tile_addr", 32'(tile_addr[TILE_AW-1:0]), 32'd0);
    tick();
    check("single_font_early", 32'(font_addr[10:0]), 32'd0);
    tick();
    check("single_font_addr", 32'(font_addr[10:0]), 32'h208);
    tick();
    check_nv("single_early");
    tick();
    check_px("single_result", 8'hE0);
    tick();
    check_nv("single_one_shot");

    // Scroll wrap: px=0 -> mx=127 (tile 15), px=1 -> mx=0 (tile 0)
    wr_reg(0, 127);
    bus.pixel_re   = 1'b1;
    bus.pixel_addr = 13'd0;
    tick();
    bus.pixel_addr = 13'd1;
    check("wrap_tile_px0", 32'(tile_addr[TILE_AW-1:0]), 32'd15);
    tick();
    bus.pixel_re = 1'b0;
    check("wrap_tile_px1", 32'(tile_addr[TILE_AW-1:0]), 32'd0);
    tick();
    check("wrap_font_px0", 32'(font_addr[10:0]), 32'h210);
    tick();
    check("wrap_font_px1", 32'(font_addr[10:0]), 32'h208);
    tick();
    check_px("wrap_data_px0", 8'h1F);
    tick();
    check_px("wrap_data_px1", 8'hE0);
    tick();
    check_nv("wrap_done");
    wr_reg(0, 0);

    // Priority between layers and background
    wr_reg(6, 1);
    pix("prio_both", 8, 8'h1C);
    pix("prio_l1_only", 9, 8'h03);
    wr_reg(15, 8'h55);
    pix("prio_bg", 10, 8'h55);
`ifdef TILEMAP_MIXER_SHADOW_EN
    wr_reg(2, 0);
    pix("prio_l0_off", 8, 8'h03);
`else
    // Write and request in the same cycle: request still sees layer 0 enabled
    bus.reg_we     = 1'b1;
    bus.reg_addr   = 4'd2;
    bus.reg_data   = 16'd0;
    bus.pixel_re   = 1'b1;
    bus.pixel_addr = 13'd8;
    tick();
    bus.reg_we = 1'b0;
    m_en[0]    = 0;
    tick();
    bus.pixel_re = 1'b0;
    repeat (3) tick();
    check_px("wr_same_cycle_old", 8'h1C);
    tick();
    check_px("wr_next_cycle_new", 8'h03);
    tick();
`endif
    wr_reg(2, 1);

    // Streaming: one full scanline back-to-back
    wr_reg(0, 2);
    wr_reg(4, 3);
    wr_reg(5, 5);
    for (int i = 0; i < 96; i++) exp_q[i] = model(i);
    for (int c = 0; c < 102; c++) begin
      if (c >= 5 && c < 101) check_px($sformatf("stream%0d", c - 5), exp_q[c-5]);
      if (c == 101) check_nv("stream_end");
      bus.pixel_re   = (c < 96);
      bus.pixel_addr = 13'(c);
      tick();
    end
    bus.pixel_re = 1'b0;
    pix("oob_6144", 6144, 8'h55);
    pix("oob_8191", 8191, 8'h55);

    // Reset with three requests in flight
    for (int c = 0; c < 5; c++) begin
      bus.pixel_re   = (c < 3);
      bus.pixel_addr = 13'(40 + c);
      rst            = (c == 4);
      tick();
    end
    rst = 1'b0;
    bus.pixel_re = 1'b0;
    model_reset();
    check("rst2_tile_addr", 32'(tile_addr), 32'd0);
    check("rst2_font_addr", 32'(font_addr), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check_nv($sformatf("rst2_no_valid%0d", c));
      tick();
    end
    pix("rst2_scroll_default", 0, 8'hE0);
    pix("rst2_l1_bg_default", 9, 8'h00);

`ifdef TILEMAP_MIXER_SHADOW_EN
    bus.reg_we   = 1'b1;
    bus.reg_addr = 4'd0;
    bus.reg_data = 16'd8;
    tick();
    bus.reg_we = 1'b0;
    pix("shadow_old", 5, 8'hE0);
    bus.pixel_re   = 1'b1;
    bus.pixel_addr = 13'd0;
    tick();
    bus.pixel_addr = 13'd5;
    tick();
    bus.pixel_re = 1'b0;
    repeat (3) tick();
    check_px("shadow_commit", 8'h1C);
    tick();
    check_px("shadow_after", 8'h1C);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
